// File: rtl/memory_controller.sv
// ---------------------------------------------------------------------------
// memory_controller
//
// Byte-serial arbiter between the core and a single-port 8-bit RAM/IO bus.
// Three requesters share the bus with fixed priority store > load > fetch.
// Loads and fetches are issued one byte per cycle and reassembled
// little-endian. Loads are sign- or zero-extended. Stores are written out
// one byte per cycle.
//
// Op-type encoding on op_type_store / op_type_load:
//   LB=10 LH=11 LW=12 LBU=13 LHU=14 SB=15 SH=16 SW=17
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (pause when low), roll_back
//   mem_din      : RAM read byte, valid one cycle after its address
//   mem_dout     : RAM write byte
//   mem_a        : RAM byte address
//   mem_wr       : write strobe
//   io_buffer_full                     : IO write back-pressure
//   lsb_store / store_address / data_store / op_type_store -> finish_store
//   lsb_load / load_address / op_type_load -> finish_load, data_load
//   fetch_req / fetch_addr -> fetch_done, fetch_data
// ---------------------------------------------------------------------------
module memory_controller #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_HI      = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  lsb_store,
    input  logic [ADDR_WIDTH-1:0] store_address,
    input  logic [31:0]           data_store,
    input  logic [5:0]            op_type_store,
    output logic                  finish_store,
    input  logic                  lsb_load,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [5:0]            op_type_load,
    output logic                  finish_load,
    output logic [31:0]           data_load,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_done,
    output logic [31:0]           fetch_data
);

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [5:0]            op_q, op_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           asm_q, asm_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            issue_q, issue_d;
    logic [2:0]            cap_q, cap_d;
    logic [2:0]            issue_eff;
    logic                  resume_q;
    logic [31:0]           data_load_q, data_load_d;
    logic [31:0]           fetch_data_q, fetch_data_d;
    logic                  finish_store_q, finish_store_d;
    logic                  finish_load_q, finish_load_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  store_blocked;

    function automatic logic [2:0] byte_count(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: byte_count = 3'd1;
            OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
            default:              byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[7:0];
        h = word[15:0];
        case (op)
            OP_LB:   extend_load = 32'(b);
            OP_LH:   extend_load = 32'(h);
            OP_LBU:  extend_load = {24'h0, word[7:0]};
            OP_LHU:  extend_load = {16'h0, word[15:0]};
            OP_LW:   extend_load = word;
            default: extend_load = word;
        endcase
    endfunction

    // An IO store must wait for room in the IO buffer; while it waits it
    // still owns the arbiter so later requests cannot overtake it.
    assign store_blocked = (store_address[17:16] == IO_HI) && io_buffer_full;

    // On the first cycle after a pause the byte in flight is lost, so
    // issuing restarts from the first uncaptured byte.
    assign issue_eff = resume_q ? cap_q : issue_q;

    // ---- state register ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            n_q            <= 3'd0;
            issue_q        <= 3'd0;
            cap_q          <= 3'd0;
            resume_q       <= 1'b0;
            finish_store_q <= 1'b0;
            finish_load_q  <= 1'b0;
            fetch_done_q   <= 1'b0;
            data_load_q    <= 32'h0;
            fetch_data_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            issue_q        <= issue_d;
            cap_q          <= cap_d;
            resume_q       <= ~rdy_in;
            finish_store_q <= finish_store_d;
            finish_load_q  <= finish_load_d;
            fetch_done_q   <= fetch_done_d;
            data_load_q    <= data_load_d;
            fetch_data_q   <= fetch_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        base_q  <= base_d;
        op_q    <= op_d;
        wdata_q <= wdata_d;
        asm_q   <= asm_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        op_d           = op_q;
        wdata_d        = wdata_q;
        asm_d          = asm_q;
        n_d            = n_q;
        issue_d        = issue_q;
        cap_d          = cap_q;
        data_load_d    = data_load_q;
        fetch_data_d   = fetch_data_q;
        // Done pulses last one active cycle; a pause stretches them.
        finish_store_d = finish_store_q & ~rdy_in;
        finish_load_d  = finish_load_q & ~rdy_in;
        fetch_done_d   = fetch_done_q & ~rdy_in;

        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (!roll_back) begin
                        if (lsb_store) begin
                            if (!store_blocked) begin
                                state_d = S_STORE;
                                base_d  = store_address;
                                op_d    = op_type_store;
                                wdata_d = data_store;
                                n_d     = byte_count(op_type_store);
                                issue_d = 3'd0;
                                cap_d   = 3'd0;
                            end
                        end else if (lsb_load) begin
                            state_d = S_LOAD;
                            base_d  = load_address;
                            op_d    = op_type_load;
                            n_d     = byte_count(op_type_load);
                            issue_d = 3'd0;
                            cap_d   = 3'd0;
                            asm_d   = 32'h0;
                        end else if (fetch_req) begin
                            state_d = S_FETCH;
                            base_d  = fetch_addr;
                            op_d    = OP_LW;
                            n_d     = 3'd4;
                            issue_d = 3'd0;
                            cap_d   = 3'd0;
                            asm_d   = 32'h0;
                        end
                    end
                end
                S_LOAD, S_FETCH: begin
                    if (roll_back) begin
                        state_d = S_IDLE;
                    end else begin
                        if (issue_eff < n_q) begin
                            issue_d = issue_eff + 3'd1;
                        end else begin
                            issue_d = issue_eff;
                        end
                        // A byte is captured the cycle after its address,
                        // except right after a pause when mem_din is stale.
                        if (!resume_q && (cap_q < issue_q)) begin
                            asm_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                            cap_d = cap_q + 3'd1;
                            if (cap_q == n_q - 3'd1) begin
                                state_d = S_DONE;
                                if (state_q == S_LOAD) begin
                                    data_load_d   = extend_load(op_q, asm_d);
                                    finish_load_d = 1'b1;
                                end else begin
                                    fetch_data_d  = asm_d;
                                    fetch_done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_STORE: begin
                    // Stores are committed: roll_back is ignored here.
                    if (issue_q == n_q - 3'd1) begin
                        state_d        = S_DONE;
                        finish_store_d = 1'b1;
                    end else begin
                        issue_d = issue_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ---- output logic ----
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h0;
        case (state_q)
            S_LOAD, S_FETCH: begin
                if (issue_eff < n_q) begin
                    mem_a = base_q + ADDR_WIDTH'(issue_eff);
                end
            end
            S_STORE: begin
                mem_a    = base_q + ADDR_WIDTH'(issue_q);
                mem_wr   = rdy_in;
                mem_dout = wdata_q[{issue_q[1:0], 3'b000} +: 8];
            end
            default: begin
                mem_a = '0;
            end
        endcase
    end

    assign finish_store = finish_store_q;
    assign finish_load  = finish_load_q;
    assign fetch_done   = fetch_done_q;
    assign data_load    = data_load_q;
    assign fetch_data   = fetch_data_q;

endmodule

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
module tb_memory_controller;

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SW  = 6'd17;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, roll_back;
    logic [7:0]  mem_din = 8'h0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        lsb_store;
    logic [31:0] store_address, data_store;
    logic [5:0]  op_type_store;
    logic        finish_store;
    logic        lsb_load;
    logic [31:0] load_address;
    logic [5:0]  op_type_load;
    logic        finish_load;
    logic [31:0] data_load;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    memory_controller #(.ADDR_WIDTH(32), .IO_HI(2'b11)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
        .op_type_store(op_type_store), .finish_store(finish_store),
        .lsb_load(lsb_load), .load_address(load_address), .op_type_load(op_type_load),
        .finish_load(finish_load), .data_load(data_load),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_done(fetch_done), .fetch_data(fetch_data)
    );

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 8'h13;
            32'h0000_0001: rom = 8'h05;
            32'h0000_0002: rom = 8'h10;
            32'h0000_0003: rom = 8'h00;
            32'h0000_0040: rom = 8'h80;
            32'h0000_0050: rom = 8'h34;
            32'h0000_0051: rom = 8'hF2;
            32'h0000_0100: rom = 8'h11;
            32'h0000_0101: rom = 8'h22;
            32'h0000_0102: rom = 8'h33;
            32'h0000_0103: rom = 8'h44;
            32'hFFFF_FFFE: rom = 8'hAA;
            32'hFFFF_FFFF: rom = 8'hBB;
            default:       rom = 8'h00;
        endcase
    endfunction

    // Synchronous-read RAM: data appears the cycle after its address.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= rom(mem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // which: 0 = finish_load, 1 = fetch_done, 2 = finish_store
    task automatic wait_done(input int which, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            nxt();
            smp();
            if ((which == 0 && finish_load === 1'b1) ||
                (which == 1 && fetch_done === 1'b1) ||
                (which == 2 && finish_store === 1'b1)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_read(input string tag, input logic is_fetch, input logic [31:0] addr,
                           input logic [5:0] op, input logic [31:0] exp, input int lat);
        int t0;
        int seen;
        logic dn;
        nxt();
        if (is_fetch) begin
            fetch_req = 1'b1; fetch_addr = addr;
        end else begin
            lsb_load = 1'b1; load_address = addr; op_type_load = op;
        end
        t0   = cyc;
        seen = -1;
        for (int i = 0; i < 30; i++) begin
            smp();
            if (i >= 1 && i <= lat - 2) begin
                check({tag, " addr"}, mem_a, addr + 32'(i - 1));
                check({tag, " wr"}, 32'(mem_wr), 32'd0);
            end
            dn = is_fetch ? fetch_done : finish_load;
            if (dn === 1'b1) begin
                seen = cyc - t0;
                break;
            end
            nxt();
        end
        fetch_req = 1'b0;
        lsb_load  = 1'b0;
        check({tag, " latency"}, 32'(seen), 32'(lat));
        check({tag, " data"}, is_fetch ? fetch_data : data_load, exp);
        nxt();
        smp();
        dn = is_fetch ? fetch_done : finish_load;
        check({tag, " pulse width"}, 32'(dn), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t0;
        int   t1;
        int   at;
        logic seen_fl;
        logic [31:0] w;

        rst_in = 1'b1; rdy_in = 1'b0; roll_back = 1'b1; io_buffer_full = 1'b0;
        lsb_store = 1'b0; store_address = 32'h0; data_store = 32'h0; op_type_store = 6'd0;
        lsb_load = 1'b1; load_address = 32'h100; op_type_load = OP_LW;
        fetch_req = 1'b1; fetch_addr = 32'h0;

        // Reset dominates rdy_in, roll_back and pending requests.
        repeat (3) nxt();
        smp();
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", 32'(mem_wr), 32'd0);
        check("reset mem_dout", 32'(mem_dout), 32'd0);
        check("reset dones", {29'd0, finish_store, finish_load, fetch_done}, 32'd0);
        check("reset data_load", data_load, 32'h0);
        check("reset fetch_data", fetch_data, 32'h0);
        nxt();
        rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; lsb_load = 1'b0; fetch_req = 1'b0;
        smp();
        check("post-reset mem_a", mem_a, 32'h0);

        // Loads: width, extension and address wrap.
        do_read("LW", 1'b0, 32'h100, OP_LW, 32'h4433_2211, 6);
        do_read("LB", 1'b0, 32'h40, OP_LB, 32'hFFFF_FF80, 3);
        do_read("LBU", 1'b0, 32'h40, OP_LBU, 32'h0000_0080, 3);
        do_read("LH", 1'b0, 32'h50, OP_LH, 32'hFFFF_F234, 4);
        do_read("LHU", 1'b0, 32'h50, OP_LHU, 32'h0000_F234, 4);
        do_read("LW wrap", 1'b0, 32'hFFFF_FFFE, OP_LW, 32'h0513_BBAA, 6);
        do_read("fetch", 1'b1, 32'h0, OP_LW, 32'h0010_0513, 6);

        // roll_back in IDLE blocks acceptance.
        nxt();
        lsb_load = 1'b1; load_address = 32'h40; op_type_load = OP_LB; roll_back = 1'b1;
        nxt();
        roll_back = 1'b0; lsb_load = 1'b0;
        smp();
        check("idle rollback no accept", mem_a, 32'h0);
        nxt();

        // SW with concurrent fetch: store wins, fetch follows.
        nxt();
        lsb_store = 1'b1; store_address = 32'h200; data_store = 32'hDEAD_BEEF; op_type_store = OP_SW;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        t0 = cyc;
        smp();
        check("SW idle wr", 32'(mem_wr), 32'd0);
        w = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            smp();
            check("SW wr", 32'(mem_wr), 32'd1);
            check("SW addr", mem_a, 32'h1FF + 32'(i));
            check("SW dout", 32'(mem_dout), (w >> (8 * (i - 1))) & 32'hFF);
        end
        nxt();
        smp();
        check("SW finish", 32'(finish_store), 32'd1);
        check("SW done wr", 32'(mem_wr), 32'd0);
        check("SW done addr", mem_a, 32'h0);
        lsb_store = 1'b0;
        t1 = cyc;
        check("SW latency", 32'(t1 - t0), 32'd5);
        wait_done(1, at);
        fetch_req = 1'b0;
        check("fetch after SW delay", 32'(at - t1), 32'd7);
        check("fetch after SW data", fetch_data, 32'h0010_0513);
        nxt();

        // IO store held off by io_buffer_full, with a load waiting behind it.
        nxt();
        io_buffer_full = 1'b1;
        lsb_store = 1'b1; store_address = 32'h3_0000; data_store = 32'h41; op_type_store = OP_SB;
        lsb_load = 1'b1; load_address = 32'h40; op_type_load = OP_LB;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("IO blocked addr", mem_a, 32'h0);
            check("IO blocked wr", 32'(mem_wr), 32'd0);
            nxt();
        end
        io_buffer_full = 1'b0;
        t0 = cyc;
        smp();
        check("IO release addr", mem_a, 32'h0);
        check("IO release wr", 32'(mem_wr), 32'd0);
        nxt();
        smp();
        check("IO write wr", 32'(mem_wr), 32'd1);
        check("IO write addr", mem_a, 32'h3_0000);
        check("IO write dout", 32'(mem_dout), 32'h41);
        nxt();
        smp();
        check("IO finish", 32'(finish_store), 32'd1);
        check("IO latency", 32'(cyc - t0), 32'd2);
        lsb_store = 1'b0;
        t1 = cyc;
        wait_done(0, at);
        lsb_load = 1'b0;
        check("queued load delay", 32'(at - t1), 32'd4);
        check("queued load data", data_load, 32'hFFFF_FF80);
        nxt();

        // roll_back at T+3 of LW: aborted, no finish_load.
        nxt();
        lsb_load = 1'b1; load_address = 32'h100; op_type_load = OP_LW;
        nxt(); nxt(); nxt();
        roll_back = 1'b1; lsb_load = 1'b0;
        smp();
        check("LW rollback addr", mem_a, 32'h102);
        nxt();
        roll_back = 1'b0;
        smp();
        check("LW rollback idle", mem_a, 32'h0);
        seen_fl = finish_load;
        for (int i = 0; i < 6; i++) begin
            nxt();
            smp();
            seen_fl = seen_fl | finish_load;
        end
        check("LW rollback no finish", 32'(seen_fl), 32'd0);

        // roll_back at T+2 of SW: ignored.
        nxt();
        lsb_store = 1'b1; store_address = 32'h210; data_store = 32'h1234_5678; op_type_store = OP_SW;
        t0 = cyc;
        nxt(); nxt();
        roll_back = 1'b1;
        smp();
        check("SW rollback wr", 32'(mem_wr), 32'd1);
        check("SW rollback addr", mem_a, 32'h211);
        nxt();
        roll_back = 1'b0;
        smp();
        check("SW rollback next addr", mem_a, 32'h212);
        nxt();
        smp();
        check("SW rollback last addr", mem_a, 32'h213);
        check("SW rollback last dout", 32'(mem_dout), 32'h12);
        nxt();
        smp();
        check("SW rollback finish", 32'(finish_store), 32'd1);
        check("SW rollback latency", 32'(cyc - t0), 32'd5);
        lsb_store = 1'b0;
        nxt();

        // rdy_in low for 3 cycles while fetch byte 2 is in flight.
        nxt();
        fetch_req = 1'b1; fetch_addr = 32'h0;
        t0 = cyc;
        for (int i = 1; i <= 3; i++) begin
            nxt();
            smp();
            check("rdy pre addr", mem_a, 32'(i - 1));
        end
        nxt();
        rdy_in = 1'b0;
        nxt();
        nxt();
        smp();
        check("rdy pause wr", 32'(mem_wr), 32'd0);
        check("rdy pause done", 32'(fetch_done), 32'd0);
        nxt();
        rdy_in = 1'b1;
        smp();
        check("rdy resume readdress", mem_a, 32'h2);
        wait_done(1, at);
        fetch_req = 1'b0;
        check("rdy fetch latency", 32'(at - t0), 32'd10);
        check("rdy fetch data", fetch_data, 32'h0010_0513);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Byte-serial arbiter between the core and the single-port 8-bit RAM/IO bus. Serves three requesters: committed stores and head-of-queue loads from the load/store buffer, and 32-bit instruction fetches from the fetch unit. Assembles and sign-extends load data, serialises store data, and honours `roll_back` and the IO-buffer-full back-pressure.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `IO_HI`, 2'b11: value of `addr[17:16]` that marks an IO address.

- `clk_in` in 1: system clock.
- `rst_in` in 1: reset; synchronous, active-high.
- `rdy_in` in 1: pause when low.
- `roll_back` in 1: misprediction flush.
- `mem_din` in 8: RAM read byte, valid one cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write `mem_dout` to `mem_a` this cycle.
- `io_buffer_full` in 1: IO output buffer full.
- `lsb_store`, `store_address`[32], `data_store`[32], `op_type_store`[6] in: store request (level, held until `finish_store`).
- `finish_store` out 1: one-cycle store completion pulse.
- `lsb_load`, `load_address`[32], `op_type_load`[6] in: load request (level).
- `finish_load` out 1, `data_load` out 32: one-cycle completion pulse with extended result.
- `fetch_req` in 1, `fetch_addr` in 32: instruction word request (level).
- `fetch_done` out 1, `fetch_data` out 32: one-cycle pulse with little-endian word.

## Operation
- States: IDLE, FETCH, LOAD, STORE, DONE.
- IDLE: sample requests; priority store > load > fetch. Latch base address, op, and store data; set byte count n from op (`SB`/`LB`/`LBU`=1, `SH`/`LH`/`LHU`=2, `SW`/`LW`=4, fetch=4). Go to the matching state.
- A store with `addr[17:16]==IO_HI` is not accepted while `io_buffer_full`=1. It stays pending and blocks lower-priority requests.
- LOAD/FETCH: two counters, issue_idx and cap_idx. Each cycle drive `mem_a`=base+issue_idx while issue_idx<n. Capture `mem_din` into byte cap_idx of the assembly register one cycle after that byte's address.
- STORE: each cycle drive `mem_wr`=1, `mem_a`=base+i, `mem_dout`=data_store[8i+7:8i], for i=0..n-1.
- Last byte done: go to DONE and pulse the matching done output for exactly one cycle. In DONE, `mem_wr`=0, `mem_a`=0, and all requests are ignored (requesters drop their level on the following edge). Return to IDLE next cycle.
- Load extension: `LB`/`LH` sign-extend from bit 7/15; `LBU`/`LHU` zero-extend; `LW` passes through. `data_load` and `fetch_data` hold their value until the next completion.
- Address arithmetic: base+i is 32-bit and wraps modulo 2^32.
- `roll_back`:
  - In LOAD/FETCH: abort to IDLE next cycle, with no done pulse.
  - In STORE/DONE: no effect, since the store is already committed and latched; `finish_store` still pulses.
  - In IDLE: no request is accepted that cycle.
- `rdy_in` low: all state and counters frozen, `mem_wr` forced 0. On the first cycle after `rdy_in` returns, issue_idx is set to cap_idx: the uncaptured byte is re-addressed and that cycle's `mem_din` is discarded. A store resumes at its current byte.
- Idle outputs: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.

## Timing
- Reset values: state IDLE; `mem_a`=0, `mem_wr`=0, `mem_dout`=0; `finish_store`=`finish_load`=`fetch_done`=0; `data_load`=`fetch_data`=0; counters 0. Reset overrides `roll_back` and `rdy_in`.
- Request sampled in IDLE at cycle T.
- Reads of n bytes: addresses driven at T+1..T+n; bytes captured at T+2..T+n+1; done pulse at T+n+2. `LW` and fetch finish at T+6, `LB` at T+3.
- Stores of n bytes: writes at T+1..T+n, `finish_store` at T+n+1. `SW` finishes at T+5.
- Next request is accepted no earlier than the cycle after the done pulse.
- Simultaneous store, load, and fetch: store first, then load, then fetch. Each is a separate transaction.

## Test plan
- `LW` at 0x100 with RAM bytes 0x11,0x22,0x33,0x44 -> `finish_load` at T+6 with `data_load`=0x44332211. `mem_a` sequence 0x100..0x103, `mem_wr`=0 throughout.
- `LB` of 0x80 -> 0xFFFFFF80; `LBU` -> 0x00000080; `LH` of bytes 0x34,0xF2 -> 0xFFFFF234.
- `SW` 0xDEADBEEF to 0x200 concurrent with `fetch_req` at 0x0 -> writes EF,BE,AD,DE to 0x200..0x203, `finish_store` at T+5. Fetch starts after DONE; `fetch_done` 7 cycles later.
- `SB` 0x41 to 0x30000 with `io_buffer_full`=1 for 5 cycles -> no write and no accept during those 5 cycles; write occurs after the flag drops; a pending `lsb_load` waits.
- `roll_back` at T+3 of an `LW`, then at T+2 of an `SW` -> load: no `finish_load`, IDLE next cycle. Store: completes, `finish_store` at T+5.
- `rdy_in` low 3 cycles during fetch byte 2 -> byte 2 re-addressed on resume. `fetch_data` correct; total latency 6+3+1 cycles.
